// File: rtl/led_frame_buffer_if.sv
// Game-logic side bus of the LED frame buffer: row writes, clear/commit
// requests, status back to the game logic, and the pixel/scan outputs that
// feed the display driver.
interface led_frame_buffer_if;
    logic              WrEn;
    logic [3:0]        WrRow;
    logic [15:0]       WrRed;
    logic [15:0]       WrGrn;
    logic              ClrReq;
    logic              Commit;
    logic              Busy;
    logic              SwapDone;
    logic              ScanTick;
    logic [15:0][15:0] RedPixels;
    logic [15:0][15:0] GrnPixels;

    modport master (
        output WrEn, WrRow, WrRed, WrGrn, ClrReq, Commit,
        input  Busy, SwapDone, ScanTick, RedPixels, GrnPixels
    );

    modport slave (
        input  WrEn, WrRow, WrRed, WrGrn, ClrReq, Commit,
        output Busy, SwapDone, ScanTick, RedPixels, GrnPixels
    );
endinterface

// File: rtl/led_frame_buffer.sv
// Double-buffered 16x16 red/green frame store. Game logic draws into the back
// buffer; a commit is copied to the front buffer only on the edge where the
// display driver wraps back to row 0, so the panel never shows a torn frame.
// Also generates the driver's row-advance enable (ScanTick).
module led_frame_buffer #(
    parameter int TICK_DIV = 1,
    parameter int FREQDIV  = 0
) (
    input  logic              Clock,
    input  logic              RST,
    led_frame_buffer_if.slave bus
);
    localparam int CNT_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int FCNT_W = FREQDIV + 4;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {IDLE, CLEAR, WAIT_SWAP} state_t;

    state_t            state_reg;
    logic [3:0]        clr_row_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic              scan_tick_reg;
    logic [FCNT_W-1:0] fcnt_reg;
    logic              busy_reg;
    logic              swap_done_reg;
    logic [15:0]       back_red_reg  [16];
    logic [15:0]       back_grn_reg  [16];
    logic [15:0]       front_red_reg [16];
    logic [15:0]       front_grn_reg [16];
    logic              frame_end;
    logic              wr_accept;

    // The last ScanTick of a frame: the driver's row counter wraps on this edge.
    assign frame_end = scan_tick_reg && (fcnt_reg == '1);
    // A row write lands only when idle and not overridden by a clear request.
    assign wr_accept = (state_reg == IDLE) && !bus.ClrReq && bus.WrEn;

    // Clock divider producing a registered one-cycle ScanTick every TICK_DIV cycles.
    always_ff @(posedge Clock) begin
        if (RST) begin
            cnt_reg       <= '0;
            scan_tick_reg <= 1'b0;
        end else if (cnt_reg == CNT_LAST) begin
            cnt_reg       <= '0;
            scan_tick_reg <= 1'b1;
        end else begin
            cnt_reg       <= cnt_reg + 1'b1;
            scan_tick_reg <= 1'b0;
        end
    end

    // Counts ScanTicks within a display frame, wrapping naturally at 16*2^FREQDIV.
    always_ff @(posedge Clock) begin
        if (RST) begin
            fcnt_reg <= '0;
        end else if (scan_tick_reg) begin
            fcnt_reg <= fcnt_reg + 1'b1;
        end
    end

    // Back buffer: one row zeroed per cycle while clearing, else accepts row writes.
    always_ff @(posedge Clock) begin
        if (RST) begin
            for (int i = 0; i < 16; i++) begin
                back_red_reg[i] <= '0;
                back_grn_reg[i] <= '0;
            end
        end else if (state_reg == CLEAR) begin
            back_red_reg[clr_row_reg] <= '0;
            back_grn_reg[clr_row_reg] <= '0;
        end else if (wr_accept) begin
            back_red_reg[bus.WrRow] <= bus.WrRed;
            back_grn_reg[bus.WrRow] <= bus.WrGrn;
        end
    end

    // Control FSM: clear sequencing, commit wait, whole-frame swap, registered status.
    always_ff @(posedge Clock) begin
        if (RST) begin
            state_reg     <= IDLE;
            clr_row_reg   <= '0;
            busy_reg      <= 1'b0;
            swap_done_reg <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                front_red_reg[i] <= '0;
                front_grn_reg[i] <= '0;
            end
        end else begin
            swap_done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.ClrReq) begin
                        state_reg   <= CLEAR;
                        clr_row_reg <= '0;
                        busy_reg    <= 1'b1;
                    end else if (bus.Commit) begin
                        // Entering the wait here means a commit seen on a
                        // frame-end cycle is held until the following frame end.
                        state_reg <= WAIT_SWAP;
                        busy_reg  <= 1'b1;
                    end
                end
                CLEAR: begin
                    clr_row_reg <= clr_row_reg + 1'b1;
                    if (clr_row_reg == 4'd15) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end
                end
                WAIT_SWAP: begin
                    if (frame_end) begin
                        for (int i = 0; i < 16; i++) begin
                            front_red_reg[i] <= back_red_reg[i];
                            front_grn_reg[i] <= back_grn_reg[i];
                        end
                        swap_done_reg <= 1'b1;
                        state_reg     <= IDLE;
                        busy_reg      <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    // Present each front row on the driver's [row][col] pixel buses.
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_pix_row
            assign bus.RedPixels[gi] = front_red_reg[gi];
            assign bus.GrnPixels[gi] = front_grn_reg[gi];
        end
    endgenerate

    assign bus.Busy     = busy_reg;
    assign bus.SwapDone = swap_done_reg;
    assign bus.ScanTick = scan_tick_reg;
endmodule

// File: tb/tb_led_frame_buffer.sv
// Self-checking bench for led_frame_buffer. DUT A (TICK_DIV=1, FREQDIV=0) is
// checked every cycle against a frame-level reference model; DUT B
// (TICK_DIV=3, FREQDIV=1) covers the slower tick rate and longer frame.
module tb_led_frame_buffer;
    localparam int TA = 1;
    localparam int FA = 0;
    localparam int PA = TA * 16 * (1 << FA);   // cycles per frame, DUT A
    localparam int TB = 3;
    localparam int FB = 1;
    localparam int PB = TB * 16 * (1 << FB);   // cycles per frame, DUT B

    logic Clock = 1'b0;
    logic RST   = 1'b1;

    led_frame_buffer_if ifa ();
    led_frame_buffer_if ifb ();

    led_frame_buffer #(.TICK_DIV(TA), .FREQDIV(FA)) dut_a (
        .Clock (Clock),
        .RST   (RST),
        .bus   (ifa.slave)
    );

    led_frame_buffer #(.TICK_DIV(TB), .FREQDIV(FB)) dut_b (
        .Clock (Clock),
        .RST   (RST),
        .bus   (ifb.slave)
    );

    always #5 Clock = ~Clock;

    int checks = 0;
    int errors = 0;

    // Reference model: n = clock edges since reset release; a frame ends on
    // every multiple of the frame period. Clear = countdown of rows left,
    // commit = a pending flag.
    int          n;
    int          clr_left;
    bit          pending;
    bit          m_sd;
    logic [15:0] m_back_red  [16];
    logic [15:0] m_back_grn  [16];
    logic [15:0] m_front_red [16];
    logic [15:0] m_front_grn [16];

    typedef struct {
        logic        wr;
        logic [3:0]  row;
        logic [15:0] red;
        logic [15:0] grn;
        logic        clr;
        logic        commit;
        logic        busy;
        logic        sd;
        logic        st;
        logic [15:0] red2;
        logic [15:0] grn2;
    } vec_t;

    vec_t tbl [18];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] exp_pix(input bit green);
        logic [255:0] v;
        for (int r = 0; r < 16; r++) begin
            v[r*16 +: 16] = green ? m_front_grn[r] : m_front_red[r];
        end
        return v;
    endfunction

    task automatic model_edge();
        bit fe;
        if (RST) begin
            n        = 0;
            clr_left = 0;
            pending  = 1'b0;
            m_sd     = 1'b0;
            for (int r = 0; r < 16; r++) begin
                m_back_red[r]  = '0;
                m_back_grn[r]  = '0;
                m_front_red[r] = '0;
                m_front_grn[r] = '0;
            end
        end else begin
            fe   = (n > 0) && (n % PA == 0);
            n++;
            m_sd = 1'b0;
            if (clr_left > 0) begin
                m_back_red[16 - clr_left] = '0;
                m_back_grn[16 - clr_left] = '0;
                clr_left--;
            end else if (pending) begin
                if (fe) begin
                    for (int r = 0; r < 16; r++) begin
                        m_front_red[r] = m_back_red[r];
                        m_front_grn[r] = m_back_grn[r];
                    end
                    m_sd    = 1'b1;
                    pending = 1'b0;
                end
            end else if (ifa.ClrReq) begin
                clr_left = 16;
            end else begin
                if (ifa.WrEn) begin
                    m_back_red[ifa.WrRow] = ifa.WrRed;
                    m_back_grn[ifa.WrRow] = ifa.WrGrn;
                end
                if (ifa.Commit) pending = 1'b1;
            end
        end
    endtask

    task automatic compare_all();
        chk("busy",       256'(ifa.Busy),     256'((clr_left > 0) || pending));
        chk("swap_done",  256'(ifa.SwapDone), 256'(m_sd));
        chk("scan_tick",  256'(ifa.ScanTick), 256'((n > 0) && (n % TA == 0)));
        chk("red_pixels", ifa.RedPixels,      exp_pix(1'b0));
        chk("grn_pixels", ifa.GrnPixels,      exp_pix(1'b1));
        chk("scan_tick_b", 256'(ifb.ScanTick), 256'((n > 0) && (n % TB == 0)));
    endtask

    // One clock: model follows the edge, outputs compared on the falling edge.
    task automatic step();
        @(posedge Clock);
        model_edge();
        @(negedge Clock);
        compare_all();
    endtask

    task automatic drive_a(input logic wr, input logic [3:0] row, input logic [15:0] red,
                           input logic [15:0] grn, input logic clr, input logic commit);
        ifa.WrEn   = wr;
        ifa.WrRow  = row;
        ifa.WrRed  = red;
        ifa.WrGrn  = grn;
        ifa.ClrReq = clr;
        ifa.Commit = commit;
    endtask

    task automatic idle_b();
        ifb.WrEn   = 1'b0;
        ifb.WrRow  = '0;
        ifb.WrRed  = '0;
        ifb.WrGrn  = '0;
        ifb.ClrReq = 1'b0;
        ifb.Commit = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int  busy_cnt;
        bit  seen;
        int  m_commit;
        int  m_exp;
        int  got_n;

        drive_a(1'b0, 4'd0, 16'h0, 16'h0, 1'b0, 1'b0);
        idle_b();
        RST = 1'b1;

        // Reset: all outputs low while RST is held.
        for (int i = 0; i < 4; i++) step();
        chk("reset_busy_b", 256'(ifb.Busy), 256'(0));
        RST = 1'b0;

        // Write row 2 then commit mid-frame; swap lands on the first frame end.
        for (int i = 0; i < 18; i++) begin
            tbl[i] = '{wr: 1'b0, row: 4'd0, red: 16'h0, grn: 16'h0, clr: 1'b0, commit: 1'b0,
                       busy: 1'b1, sd: 1'b0, st: 1'b1, red2: 16'h0, grn2: 16'h0};
        end
        tbl[0].wr = 1'b1; tbl[0].row = 4'd2; tbl[0].red = 16'h000C; tbl[0].grn = 16'h0008;
        tbl[0].busy = 1'b0;
        tbl[1].commit = 1'b1;
        tbl[16].busy = 1'b0; tbl[16].sd = 1'b1; tbl[16].red2 = 16'h000C; tbl[16].grn2 = 16'h0008;
        tbl[17].busy = 1'b0; tbl[17].red2 = 16'h000C; tbl[17].grn2 = 16'h0008;

        for (int i = 0; i < 18; i++) begin
            drive_a(tbl[i].wr, tbl[i].row, tbl[i].red, tbl[i].grn, tbl[i].clr, tbl[i].commit);
            step();
            chk($sformatf("tbl%0d_busy", i), 256'(ifa.Busy),         256'(tbl[i].busy));
            chk($sformatf("tbl%0d_sd", i),   256'(ifa.SwapDone),     256'(tbl[i].sd));
            chk($sformatf("tbl%0d_st", i),   256'(ifa.ScanTick),     256'(tbl[i].st));
            chk($sformatf("tbl%0d_red2", i), 256'(ifa.RedPixels[2]), 256'(tbl[i].red2));
            chk($sformatf("tbl%0d_grn2", i), 256'(ifa.GrnPixels[2]), 256'(tbl[i].grn2));
        end
        chk("red2_bits32", 256'(ifa.RedPixels[2][3:2]), 256'(2'b11));
        drive_a(1'b0, 4'd0, 16'h0, 16'h0, 1'b0, 1'b0);

        // Commit on the frame-end cycle waits one whole frame.
        drive_a(1'b1, 4'd7, 16'hA5A5, 16'h5A5A, 1'b0, 1'b0);
        step();
        drive_a(1'b0, 4'd0, 16'h0, 16'h0, 1'b0, 1'b0);
        while (n < 32) step();
        ifa.Commit = 1'b1;
        step();
        ifa.Commit = 1'b0;
        chk("fe_commit_busy", 256'(ifa.Busy), 256'(1));
        seen = 1'b0;
        while (n < 48) begin
            step();
            if (ifa.SwapDone) seen = 1'b1;
        end
        chk("fe_commit_no_early_swap", 256'(seen), 256'(0));
        chk("fe_commit_row7_old", 256'(ifa.RedPixels[7]), 256'(16'h0000));
        step();
        chk("fe_commit_swap_done", 256'(ifa.SwapDone), 256'(1));
        chk("fe_commit_row7_new", 256'(ifa.RedPixels[7]), 256'(16'hA5A5));

        // Fill back buffer, clear it (writes during clear ignored), commit.
        for (int r = 0; r < 16; r++) begin
            drive_a(1'b1, 4'(r), 16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
            step();
        end
        drive_a(1'b0, 4'd0, 16'h0, 16'h0, 1'b1, 1'b0);
        step();
        busy_cnt = ifa.Busy ? 1 : 0;
        drive_a(1'b1, 4'd0, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            step();
            if (ifa.Busy) busy_cnt++;
            else break;
        end
        drive_a(1'b0, 4'd0, 16'h0, 16'h0, 1'b0, 1'b0);
        chk("clear_busy_cycles", 256'(busy_cnt), 256'(16));
        ifa.Commit = 1'b1;
        step();
        ifa.Commit = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            step();
            if (ifa.SwapDone) seen = 1'b1;
        end
        chk("clear_swap_seen", 256'(seen), 256'(1));
        chk("clear_front_red_zero", ifa.RedPixels, 256'(0));
        chk("clear_front_grn_zero", ifa.GrnPixels, 256'(0));

        // Clear, write and commit together: clear wins, no swap.
        drive_a(1'b1, 4'd3, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
        step();
        drive_a(1'b1, 4'd4, 16'hFFFF, 16'hFFFF, 1'b1, 1'b1);
        step();
        drive_a(1'b0, 4'd0, 16'h0, 16'h0, 1'b0, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (ifa.SwapDone) seen = 1'b1;
        end
        chk("clr_prio_no_swap", 256'(seen), 256'(0));
        chk("clr_prio_idle", 256'(ifa.Busy), 256'(0));

        // Reset while waiting for a swap drops the commit and the back buffer.
        drive_a(1'b1, 4'd1, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
        step();
        drive_a(1'b0, 4'd0, 16'h0, 16'h0, 1'b0, 1'b1);
        step();
        ifa.Commit = 1'b0;
        step();
        chk("wait_busy", 256'(ifa.Busy), 256'(1));
        RST = 1'b1;
        step();
        RST = 1'b0;
        chk("rst_wait_busy", 256'(ifa.Busy), 256'(0));
        chk("rst_wait_red", ifa.RedPixels, 256'(0));
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (ifa.SwapDone) seen = 1'b1;
        end
        chk("rst_wait_no_swap", 256'(seen), 256'(0));
        ifa.Commit = 1'b1;
        step();
        ifa.Commit = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            step();
            if (ifa.SwapDone) seen = 1'b1;
        end
        chk("rst_back_swap_seen", 256'(seen), 256'(1));
        chk("rst_back_cleared", ifa.RedPixels, 256'(0));

        // Randomised traffic against the model, with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            RST = ($urandom_range(0, 199) == 0);
            drive_a(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                    16'($urandom), 16'($urandom),
                    ($urandom_range(0, 49) == 0), ($urandom_range(0, 19) == 0));
            step();
        end
        RST = 1'b0;
        drive_a(1'b0, 4'd0, 16'h0, 16'h0, 1'b0, 1'b0);
        step();

        // DUT B: swap on the first frame end (period PB) at or after acceptance.
        ifb.WrEn  = 1'b1;
        ifb.WrRow = 4'd5;
        ifb.WrRed = 16'hFFFF;
        ifb.WrGrn = 16'h00FF;
        ifb.Commit = 1'b1;
        step();
        idle_b();
        m_commit = n;
        m_exp    = ((m_commit + PB - 1) / PB) * PB + 1;
        chk("b_busy", 256'(ifb.Busy), 256'(1));
        got_n = -1;
        for (int i = 0; i < 250 && got_n < 0; i++) begin
            step();
            if (ifb.SwapDone) got_n = n;
        end
        chk("b_swap_cycle", 256'(got_n), 256'(m_exp));
        chk("b_row5_red", 256'(ifb.RedPixels[5]), 256'(16'hFFFF));
        chk("b_row5_grn", 256'(ifb.GrnPixels[5]), 256'(16'h00FF));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
